// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants
// and width helpers used by every FIFO variant and its storage.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width for a given depth (at least one bit so a port always exists).
    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: one extra bit so the value DEPTH is representable.
    function automatic int fifo_cnt_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// FIFO storage: DATA_WIDTH x DEPTH register array with one synchronous write
// port and one asynchronous (combinational) read port. No reset: contents are
// only ever observed after having been written.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = fifo_addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the write word at the write address on an enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and a selectable read mode
// (registered read, or first-word-fall-through).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_MODE_STD,
    localparam int ADDR_W    = fifo_addr_w(DEPTH),
    localparam int CNT_W     = fifo_cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  empty_s, full_s;
    logic                  wr_acc_s, rd_acc_s, mem_we_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    // All status flags are decoded straight from the count register so they
    // move in the same cycle as the count.
    assign empty_s  = (count_q == CNT_ZERO);
    assign full_s   = (count_q == CNT_DEPTH);
    assign wr_acc_s = wr_en & ~full_s;
    assign rd_acc_s = rd_en & ~empty_s;
    // Keep the array quiet while reset is held.
    assign mem_we_s = wr_acc_s & rst;

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    // Next-state pointers and occupancy from the accepted read/write pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and error-pulse registers; rejected requests only pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_en & full_s;
            underflow_q <= rd_en & empty_s;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented continuously; zero while empty.
            assign rdata = empty_s ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
            assign valid = ~empty_s;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  valid_q;

            // Registered read: capture the head word on an accepted read.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_q <= {DATA_WIDTH{1'b0}};
                    valid_q <= 1'b0;
                end else if (rd_acc_s) begin
                    rdata_q <= mem_rdata_s;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign rdata = rdata_q;
            assign valid = valid_q;
        end
    endgenerate

    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_q <= CNT_AE);
    assign almost_full  = (count_q >= CNT_AF);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode instance driven side
// by side, each compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk;
    logic          rst;
    // Standard-mode instance (suffix 0)
    logic          wr_en0, rd_en0;
    logic [DW-1:0] wdata0, rdata0;
    logic          valid0, empty0, full0, ae0, af0, ovf0, udf0;
    logic [3:0]    count0;
    // FWFT-mode instance (suffix 1)
    logic          wr_en1, rd_en1;
    logic [DW-1:0] wdata1, rdata1;
    logic          valid1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [3:0]    count1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] m0_rdata;
    logic          m0_valid, m0_ovf, m0_udf, m1_ovf, m1_udf;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .wdata(wdata0), .rd_en(rd_en0),
        .rdata(rdata0), .valid(valid0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wdata(wdata1), .rd_en(rd_en1),
        .rdata(rdata1), .valid(valid1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_std();
        int n;
        n = q0.size();
        chk("std.count", 32'(count0), 32'(n));
        chk("std.empty", 32'(empty0), 32'(n == 0));
        chk("std.full", 32'(full0), 32'(n == DEPTH));
        chk("std.almost_empty", 32'(ae0), 32'(n <= AE));
        chk("std.almost_full", 32'(af0), 32'(n >= AF));
        chk("std.valid", 32'(valid0), 32'(m0_valid));
        chk("std.rdata", 32'(rdata0), 32'(m0_rdata));
        chk("std.overflow", 32'(ovf0), 32'(m0_ovf));
        chk("std.underflow", 32'(udf0), 32'(m0_udf));
    endtask

    task automatic check_fwft();
        int n;
        logic [DW-1:0] head;
        n = q1.size();
        head = (n == 0) ? 8'h00 : q1[0];
        chk("fwft.count", 32'(count1), 32'(n));
        chk("fwft.empty", 32'(empty1), 32'(n == 0));
        chk("fwft.full", 32'(full1), 32'(n == DEPTH));
        chk("fwft.almost_empty", 32'(ae1), 32'(n <= AE));
        chk("fwft.almost_full", 32'(af1), 32'(n >= AF));
        chk("fwft.valid", 32'(valid1), 32'(n != 0));
        chk("fwft.rdata", 32'(rdata1), 32'(head));
        chk("fwft.overflow", 32'(ovf1), 32'(m1_ovf));
        chk("fwft.underflow", 32'(udf1), 32'(m1_udf));
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m0_rdata = 8'h00;
        m0_valid = 1'b0;
        m0_ovf   = 1'b0;
        m0_udf   = 1'b0;
        m1_ovf   = 1'b0;
        m1_udf   = 1'b0;
    endtask

    // One clock cycle on both instances, then model update and full check.
    task automatic step(input logic w0, input logic [DW-1:0] d0, input logic r0,
                        input logic w1, input logic [DW-1:0] d1, input logic r1);
        bit f, e;
        wr_en0 = w0; wdata0 = d0; rd_en0 = r0;
        wr_en1 = w1; wdata1 = d1; rd_en1 = r1;
        @(posedge clk);
        #1;
        // standard model
        f = (q0.size() == DEPTH);
        e = (q0.size() == 0);
        m0_ovf = w0 && f;
        m0_udf = r0 && e;
        if (r0 && !e) begin
            m0_rdata = q0.pop_front();
            m0_valid = 1'b1;
        end else begin
            m0_valid = 1'b0;
        end
        if (w0 && !f) q0.push_back(d0);
        // FWFT model
        f = (q1.size() == DEPTH);
        e = (q1.size() == 0);
        m1_ovf = w1 && f;
        m1_udf = r1 && e;
        if (r1 && !e) void'(q1.pop_front());
        if (w1 && !f) q1.push_back(d1);
        check_std();
        check_fwft();
    endtask

    task automatic step0(input logic w0, input logic [DW-1:0] d0, input logic r0);
        step(w0, d0, r0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        wr_en0 = 1'b0; wdata0 = 8'h00; rd_en0 = 1'b0;
        wr_en1 = 1'b0; wdata1 = 8'h00; rd_en1 = 1'b0;
        model_reset();
        #3;
        check_std();
        check_fwft();
        @(negedge clk);
        rst = 1'b1;

        // FWFT: first word falls through, then pop empties; std fills 0x00..
        step(1'b1, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0);
        chk("fwft.first_word", 32'(rdata1), 32'h5C);
        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft.pop_valid", 32'(valid1), 32'h0);
        for (int i = 2; i < 8; i++) step0(1'b1, 8'(i), 1'b0);
        chk("std.full_after_fill", 32'(full0), 32'h1);
        step0(1'b1, 8'hAA, 1'b0);
        chk("std.overflow_pulse", 32'(ovf0), 32'h1);

        // Drain nine times: 0x00..0x07 in order then one underflow.
        for (int i = 0; i < 9; i++) begin
            step0(1'b0, 8'h00, 1'b1);
            if (i < 8) chk("std.drain_order", 32'(rdata0), 32'(i));
        end
        chk("std.underflow_pulse", 32'(udf0), 32'h1);
        chk("std.rdata_hold", 32'(rdata0), 32'h07);
        step0(1'b0, 8'h00, 1'b0);

        // Mid-level simultaneous traffic with pointer wrap.
        for (int i = 0; i < 4; i++) step0(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) step0(1'b1, 8'(8'h10 + i), 1'b1);
        chk("std.simul_count", 32'(count0), 32'h4);

        // Fill, then both requests while full.
        for (int i = 0; i < 4; i++) step0(1'b1, 8'(8'h40 + i), 1'b0);
        step0(1'b1, 8'hEE, 1'b1);
        chk("std.full_both_count", 32'(count0), 32'h7);
        chk("std.full_both_ovf", 32'(ovf0), 32'h1);

        // Down to 5, then asynchronous reset between edges.
        step0(1'b0, 8'h00, 1'b1);
        step0(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("std.count_before_rst", 32'(count0), 32'h5);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_std();
        check_fwft();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("std.udf_after_rst", 32'(udf0), 32'h1);

        // Randomised traffic: fill-biased then drain-biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 60; i++) begin
                int bias;
                bias = (ph % 2 == 0) ? 3 : 1;
                step(($urandom_range(0, 3) < bias), 8'($urandom), ($urandom_range(0, 3) >= bias),
                     ($urandom_range(0, 3) < bias), 8'($urandom), ($urandom_range(0, 3) >= bias));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
